// File: rtl/cpu_run_checker.sv
// cpu_run_checker: holds the CPU in reset, lets it run until halt or a cycle
// limit, freezes it, then compares probed architectural values with expected
// values one channel per cycle and reports the verdict on status outputs/LEDs.
module cpu_run_checker #(
  parameter int DATA_W     = 32,
  parameter int N_CHK      = 4,
  parameter int CYC_W      = 16,
  parameter int RUN_CYCLES = 100,
  parameter int RST_CYCLES = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_halt,
  input  logic [N_CHK-1:0]        i_chk_en,
  input  logic [N_CHK*DATA_W-1:0] i_probe_vals,
  input  logic [N_CHK*DATA_W-1:0] i_expect_vals,
  output logic                    o_cpu_rst,
  output logic                    o_cpu_run,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic [N_CHK-1:0]        o_fail_mask,
  output logic [CYC_W-1:0]        o_cycle_count,
  output logic [3:0]              o_led
);

  localparam int IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1;
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [RST_W-1:0]   r_rstCnt;
  logic [IDX_W-1:0]   r_idx;
  logic [CYC_W-1:0]   r_cycleCount;
  logic               r_timeout;
  logic [N_CHK-1:0]   r_failMask;
  logic               r_pass;
  logic               r_done;
  logic               r_cpuRst;
  logic               r_cpuRun;
  logic               r_busy;
  logic [3:0]         r_led;

  state_t             w_stateNext;
  logic [RST_W-1:0]   w_rstCntNext;
  logic [IDX_W-1:0]   w_idxNext;
  logic [CYC_W-1:0]   w_cycleNext;
  logic [CYC_W-1:0]   w_cycleInc;
  logic               w_timeoutNext;
  logic [N_CHK-1:0]   w_failNext;
  logic               w_passNext;
  logic               w_doneNext;
  logic               w_cpuRstNext;
  logic               w_cpuRunNext;
  logic               w_busyNext;
  logic [3:0]         w_ledNext;
  logic [DATA_W-1:0]  w_probeSel;
  logic [DATA_W-1:0]  w_expectSel;

  assign w_cycleInc  = r_cycleCount + 1'b1;
  assign w_probeSel  = i_probe_vals[r_idx*DATA_W +: DATA_W];
  assign w_expectSel = i_expect_vals[r_idx*DATA_W +: DATA_W];

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    w_stateNext   = r_state;
    w_rstCntNext  = r_rstCnt;
    w_idxNext     = r_idx;
    w_cycleNext   = r_cycleCount;
    w_timeoutNext = r_timeout;
    w_failNext    = r_failMask;
    w_passNext    = r_pass;
    w_doneNext    = r_done;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_stateNext   = S_RST;
          w_rstCntNext  = '0;
          w_idxNext     = '0;
          w_cycleNext   = '0;
          w_timeoutNext = 1'b0;
          w_failNext    = '0;
          w_passNext    = 1'b0;
          w_doneNext    = 1'b0;
        end
      end
      S_RST: begin
        if (r_rstCnt == RST_W'(RST_CYCLES - 1)) begin
          w_stateNext = S_RUN;
        end else begin
          w_rstCntNext = r_rstCnt + 1'b1;
        end
      end
      S_RUN: begin
        w_cycleNext = w_cycleInc;
        if (i_halt) begin
          w_stateNext = S_CHECK;
          w_idxNext   = '0;
        end else if (w_cycleInc == CYC_W'(RUN_CYCLES)) begin
          w_stateNext   = S_CHECK;
          w_idxNext     = '0;
          w_timeoutNext = 1'b1;
        end
      end
      S_CHECK: begin
        w_failNext[r_idx] = i_chk_en[r_idx] && (w_probeSel != w_expectSel);
        if (r_idx == IDX_W'(N_CHK - 1)) begin
          w_stateNext = S_DONE;
          w_doneNext  = 1'b1;
          w_passNext  = (w_failNext == '0) && !r_timeout;
        end else begin
          w_idxNext = r_idx + 1'b1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    w_cpuRstNext = (w_stateNext == S_IDLE) || (w_stateNext == S_RST);
    w_cpuRunNext = (w_stateNext == S_RUN);
    w_busyNext   = (w_stateNext == S_RST) || (w_stateNext == S_RUN) ||
                   (w_stateNext == S_CHECK);
    w_ledNext    = {w_timeoutNext, w_doneNext && !w_passNext,
                    w_doneNext && w_passNext, w_busyNext};
  end

  // State and registered outputs; reset aborts any test in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_rstCnt     <= '0;
      r_idx        <= '0;
      r_cycleCount <= '0;
      r_timeout    <= 1'b0;
      r_failMask   <= '0;
      r_pass       <= 1'b0;
      r_done       <= 1'b0;
      r_cpuRst     <= 1'b1;
      r_cpuRun     <= 1'b0;
      r_busy       <= 1'b0;
      r_led        <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_rstCnt     <= w_rstCntNext;
      r_idx        <= w_idxNext;
      r_cycleCount <= w_cycleNext;
      r_timeout    <= w_timeoutNext;
      r_failMask   <= w_failNext;
      r_pass       <= w_passNext;
      r_done       <= w_doneNext;
      r_cpuRst     <= w_cpuRstNext;
      r_cpuRun     <= w_cpuRunNext;
      r_busy       <= w_busyNext;
      r_led        <= w_ledNext;
    end
  end

  assign o_cpu_rst     = r_cpuRst;
  assign o_cpu_run     = r_cpuRun;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pass        = r_pass;
  assign o_timeout     = r_timeout;
  assign o_fail_mask   = r_failMask;
  assign o_cycle_count = r_cycleCount;
  assign o_led         = r_led;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Directed self-checking bench for cpu_run_checker with default parameters.
// Cycle numbers below are counted from the edge that samples start (cycle 1 is
// the first cycle after that edge).
module tb_cpu_run_checker;

  localparam int DATA_W = 32;
  localparam int N_CHK  = 4;
  localparam int CYC_W  = 16;

  logic                    i_clock;
  logic                    i_reset;
  logic                    i_start;
  logic                    i_halt;
  logic [N_CHK-1:0]        i_chk_en;
  logic [N_CHK*DATA_W-1:0] i_probe_vals;
  logic [N_CHK*DATA_W-1:0] i_expect_vals;
  logic                    o_cpu_rst;
  logic                    o_cpu_run;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_pass;
  logic                    o_timeout;
  logic [N_CHK-1:0]        o_fail_mask;
  logic [CYC_W-1:0]        o_cycle_count;
  logic [3:0]              o_led;

  int nChecks = 0;
  int nFail   = 0;

  int   doneCyc;
  logic rstWinOk;
  logic cyc1Done;
  logic cyc1Busy;

  cpu_run_checker dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_halt        (i_halt),
    .i_chk_en      (i_chk_en),
    .i_probe_vals  (i_probe_vals),
    .i_expect_vals (i_expect_vals),
    .o_cpu_rst     (o_cpu_rst),
    .o_cpu_run     (o_cpu_run),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pass        (o_pass),
    .o_timeout     (o_timeout),
    .o_fail_mask   (o_fail_mask),
    .o_cycle_count (o_cycle_count),
    .o_led         (o_led)
  );

  // Free-running 10-time-unit clock.
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one test: halt is raised in RUN cycle haltK (0 = never), start is
  // re-pulsed in cycles startA/startB (0 = never). Returns the cycle in which
  // done was first seen (-1 if it never came within the budget).
  task automatic applyStimulus(input int haltK, input int startA, input int startB,
                               output int doneAt, output logic rstOk,
                               output logic done1, output logic busy1);
    int cyc;
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    cyc    = 1;
    doneAt = -1;
    rstOk  = 1'b1;
    done1  = o_done;
    busy1  = o_busy;
    while (doneAt < 0 && cyc < 300) begin
      if (cyc == 1 || cyc == 2) rstOk = rstOk & o_cpu_rst & !o_cpu_run & o_busy;
      if (cyc == 3) rstOk = rstOk & !o_cpu_rst & o_cpu_run & o_busy;
      if (o_done) begin
        doneAt = cyc;
      end else begin
        i_halt  = (haltK > 0) && (cyc == 2 + haltK);
        i_start = (cyc == startA) || (cyc == startB);
        @(negedge i_clock);
        cyc++;
      end
    end
    i_halt  = 1'b0;
    i_start = 1'b0;
  endtask

  initial begin
    i_reset       = 1'b1;
    i_start       = 1'b0;
    i_halt        = 1'b0;
    i_chk_en      = 4'b1111;
    i_expect_vals = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    i_probe_vals  = i_expect_vals;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;

    // Reset values
    checkOutput("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
    checkOutput("rst_cpu_run", 32'(o_cpu_run), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_pass", 32'(o_pass), 32'd0);
    checkOutput("rst_timeout", 32'(o_timeout), 32'd0);
    checkOutput("rst_fail_mask", 32'(o_fail_mask), 32'd0);
    checkOutput("rst_cycle_count", 32'(o_cycle_count), 32'd0);
    checkOutput("rst_led", 32'(o_led), 32'd0);

    // Test A: all match, halt in RUN cycle 10
    applyStimulus(10, 0, 0, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("A_rst_window", 32'(rstWinOk), 32'd1);
    checkOutput("A_done_cycle", 32'(doneCyc), 32'd17);
    checkOutput("A_pass", 32'(o_pass), 32'd1);
    checkOutput("A_cycle_count", 32'(o_cycle_count), 32'd10);
    checkOutput("A_fail_mask", 32'(o_fail_mask), 32'd0);
    checkOutput("A_timeout", 32'(o_timeout), 32'd0);
    checkOutput("A_led", 32'(o_led), 32'b0010);
    checkOutput("A_busy", 32'(o_busy), 32'd0);
    checkOutput("A_frozen", 32'({o_cpu_rst, o_cpu_run}), 32'd0);

    // Test B: channel 2 mismatch, started from DONE
    i_probe_vals[2*DATA_W +: DATA_W]  = 32'hDEADBEEF;
    i_expect_vals[2*DATA_W +: DATA_W] = 32'h00000000;
    applyStimulus(10, 0, 0, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("B_done_cycle", 32'(doneCyc), 32'd17);
    checkOutput("B_fail_mask", 32'(o_fail_mask), 32'b0100);
    checkOutput("B_pass", 32'(o_pass), 32'd0);
    checkOutput("B_led", 32'(o_led), 32'b0100);

    // Test C: same mismatch but channel 2 disabled
    i_chk_en = 4'b1011;
    applyStimulus(10, 0, 0, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("C_fail_mask", 32'(o_fail_mask), 32'd0);
    checkOutput("C_pass", 32'(o_pass), 32'd1);
    checkOutput("C_led", 32'(o_led), 32'b0010);

    // Test D: halt never comes, run limit ends the test
    i_chk_en = 4'b1111;
    i_probe_vals[2*DATA_W +: DATA_W] = 32'h00000000;
    applyStimulus(0, 0, 0, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("D_done_cycle", 32'(doneCyc), 32'd107);
    checkOutput("D_timeout", 32'(o_timeout), 32'd1);
    checkOutput("D_cycle_count", 32'(o_cycle_count), 32'd100);
    checkOutput("D_pass", 32'(o_pass), 32'd0);
    checkOutput("D_fail_mask", 32'(o_fail_mask), 32'd0);
    checkOutput("D_led", 32'(o_led), 32'b1100);

    // Test E: halt in RUN cycle 100 coincides with the limit, halt wins
    applyStimulus(100, 0, 0, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("E_done_cycle", 32'(doneCyc), 32'd107);
    checkOutput("E_timeout", 32'(o_timeout), 32'd0);
    checkOutput("E_cycle_count", 32'(o_cycle_count), 32'd100);
    checkOutput("E_pass", 32'(o_pass), 32'd1);

    // Test F: start pulsed in RUN (cycle 8) and CHECK (cycle 14) is ignored
    applyStimulus(10, 8, 14, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("F_cyc1_done", 32'(cyc1Done), 32'd0);
    checkOutput("F_cyc1_busy", 32'(cyc1Busy), 32'd1);
    checkOutput("F_done_cycle", 32'(doneCyc), 32'd17);
    checkOutput("F_cycle_count", 32'(o_cycle_count), 32'd10);
    checkOutput("F_pass", 32'(o_pass), 32'd1);

    // Test G: reset in RUN cycle 5 aborts, then a fresh test completes
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (6) @(negedge i_clock);
    checkOutput("G_running", 32'({o_cpu_run, o_busy}), 32'b11);
    checkOutput("G_count_before", 32'(o_cycle_count), 32'd4);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    checkOutput("G_cpu_rst", 32'(o_cpu_rst), 32'd1);
    checkOutput("G_cpu_run", 32'(o_cpu_run), 32'd0);
    checkOutput("G_busy", 32'(o_busy), 32'd0);
    checkOutput("G_cycle_count", 32'(o_cycle_count), 32'd0);
    checkOutput("G_led", 32'(o_led), 32'd0);
    applyStimulus(10, 0, 0, doneCyc, rstWinOk, cyc1Done, cyc1Busy);
    checkOutput("G_rst_window", 32'(rstWinOk), 32'd1);
    checkOutput("G_done_cycle", 32'(doneCyc), 32'd17);
    checkOutput("G_pass", 32'(o_pass), 32'd1);
    checkOutput("G_led_after", 32'(o_led), 32'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
